// File: rtl/matrix_tx_formatter_pkg.sv
// Shared definitions for the matrix UART formatter: FSM state encoding and
// the ASCII bytes used to frame each printed element.
package matrix_tx_formatter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CONV    = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_DIGIT0 = 8'h30;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASCII_DIGIT0 | {4'h0, d};
    endfunction

endpackage

// File: rtl/matrix_tx_formatter_bin2dec8.sv
// bin2dec8: registered 8-bit binary to three BCD digits plus the count of
// significant digits (a value of 0 reports one digit).
module bin2dec8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_value,
    output logic [3:0] o_hund,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic [1:0] o_ndig,
    output logic       o_valid
);

    logic [3:0] w_hund;
    logic [6:0] w_rem;
    logic [3:0] w_tens;
    logic [3:0] w_ones;
    logic [1:0] w_ndig;

    // Split into hundreds by comparison, then tens/ones of the sub-100 remainder.
    always_comb begin
        w_hund = 4'd0;
        w_rem  = 7'd0;
        if (i_value >= 8'd200) begin
            w_hund = 4'd2;
            w_rem  = 7'(i_value - 8'd200);
        end else if (i_value >= 8'd100) begin
            w_hund = 4'd1;
            w_rem  = 7'(i_value - 8'd100);
        end else begin
            w_hund = 4'd0;
            w_rem  = i_value[6:0];
        end
        w_tens = 4'(w_rem / 7'd10);
        w_ones = 4'(w_rem % 7'd10);
        if (w_hund != 4'd0) begin
            w_ndig = 2'd3;
        end else if (w_tens != 4'd0) begin
            w_ndig = 2'd2;
        end else begin
            w_ndig = 2'd1;
        end
    end

    // Capture the digits on load; they hold until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hund  <= 4'd0;
            o_tens  <= 4'd0;
            o_ones  <= 4'd0;
            o_ndig  <= 2'd0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_load;
            if (i_load) begin
                o_hund <= w_hund;
                o_tens <= w_tens;
                o_ones <= w_ones;
                o_ndig <= w_ndig;
            end
        end
    end

endmodule

// File: rtl/matrix_tx_formatter.sv
// matrix_tx_formatter: prints an M x N matrix of unsigned bytes as decimal
// ASCII text, space separated, CR LF at each row end, through a UART handshake.
module matrix_tx_formatter #(
    parameter int MAX_DIM  = 5,
    parameter int CLR_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] dim_m,
    input  logic [2:0] dim_n,
    input  logic [7:0] elem_data,
    input  logic       elem_valid,
    output logic       elem_ready,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       error
);
    import matrix_tx_formatter_pkg::*;

    localparam int              SW         = $clog2(CLR_WAIT + 2);
    localparam logic [SW-1:0]   CLR_WAIT_C = SW'(CLR_WAIT);
    localparam logic [2:0]      MAX_DIM_C  = 3'(MAX_DIM);

    state_t        r_state;
    logic [2:0]    r_dim_m;
    logic [2:0]    r_dim_n;
    logic [2:0]    r_row;
    logic [2:0]    r_col;
    logic [2:0]    r_bidx;
    logic [2:0]    r_nbytes;
    logic [7:0]    r_byte;
    logic          r_elem_ready;
    logic          r_tx_start;
    logic [7:0]    r_tx_data;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [SW-1:0] r_since;

    logic          w_b2d_load;
    logic          w_b2d_valid;
    logic [3:0]    w_hund;
    logic [3:0]    w_tens;
    logic [3:0]    w_ones;
    logic [1:0]    w_ndig;
    logic          w_dims_bad;
    logic          w_last_col;
    logic          w_tx_ok;
    logic [2:0]    w_pos;
    logic [7:0]    w_byte;

    assign w_b2d_load = (r_state == FETCH) && elem_valid && r_elem_ready;
    assign w_dims_bad = (dim_m == 3'd0) || (dim_m > MAX_DIM_C) ||
                        (dim_n == 3'd0) || (dim_n > MAX_DIM_C);
    assign w_last_col = (r_col == (r_dim_n - 3'd1));
    // tx_busy is only meaningful once the transmitter has seen our last pulse.
    assign w_tx_ok    = !tx_busy && !r_tx_start && (r_since >= CLR_WAIT_C);

    bin2dec8 u_bin2dec8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_b2d_load),
        .i_value (elem_data),
        .o_hund  (w_hund),
        .o_tens  (w_tens),
        .o_ones  (w_ones),
        .o_ndig  (w_ndig),
        .o_valid (w_b2d_valid)
    );

    // Select byte r_bidx of the current element: significant digits, then separator(s).
    always_comb begin
        w_pos  = r_bidx + (3'd3 - {1'b0, w_ndig});
        w_byte = ASCII_SPACE;
        if (r_bidx < {1'b0, w_ndig}) begin
            case (w_pos)
                3'd0:    w_byte = digit_ascii(w_hund);
                3'd1:    w_byte = digit_ascii(w_tens);
                default: w_byte = digit_ascii(w_ones);
            endcase
        end else if (!w_last_col) begin
            w_byte = ASCII_SPACE;
        end else if (r_bidx == {1'b0, w_ndig}) begin
            w_byte = ASCII_CR;
        end else begin
            w_byte = ASCII_LF;
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_dim_m      <= 3'd0;
            r_dim_n      <= 3'd0;
            r_row        <= 3'd0;
            r_col        <= 3'd0;
            r_bidx       <= 3'd0;
            r_nbytes     <= 3'd0;
            r_byte       <= 8'h00;
            r_elem_ready <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_since      <= '0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            if (r_since < CLR_WAIT_C) begin
                r_since <= r_since + SW'(1);
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_dims_bad) begin
                            r_error <= 1'b1;
                        end else begin
                            r_dim_m      <= dim_m;
                            r_dim_n      <= dim_n;
                            r_row        <= 3'd0;
                            r_col        <= 3'd0;
                            r_busy       <= 1'b1;
                            r_elem_ready <= 1'b1;
                            r_state      <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (w_b2d_load) begin
                        r_elem_ready <= 1'b0;
                        r_state      <= CONV;
                    end
                end
                CONV: begin
                    if (w_b2d_valid) begin
                        r_nbytes <= {1'b0, w_ndig} + (w_last_col ? 3'd2 : 3'd1);
                        r_bidx   <= 3'd0;
                        r_state  <= SEND;
                    end
                end
                SEND: begin
                    r_byte  <= w_byte;
                    r_state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (w_tx_ok) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_byte;
                        r_since    <= '0;
                        if (r_bidx != (r_nbytes - 3'd1)) begin
                            r_bidx  <= r_bidx + 3'd1;
                            r_state <= SEND;
                        end else if (!w_last_col) begin
                            r_col        <= r_col + 3'd1;
                            r_elem_ready <= 1'b1;
                            r_state      <= FETCH;
                        end else if (r_row != (r_dim_m - 3'd1)) begin
                            r_col        <= 3'd0;
                            r_row        <= r_row + 3'd1;
                            r_elem_ready <= 1'b1;
                            r_state      <= FETCH;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_row   <= 3'd0;
                    r_col   <= 3'd0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy       <= 1'b0;
                    r_elem_ready <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign elem_ready = r_elem_ready;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_matrix_tx_formatter.sv
// Randomized self-checking bench: a string-formatting model of the printed
// matrix is compared byte-for-byte against every tx_start issued by the DUT.
module tb_matrix_tx_formatter;

    localparam int MAX_DIM  = 5;
    localparam int CLR_WAIT = 1;

    typedef byte unsigned bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] dim_m = 3'd0;
    logic [2:0] dim_n = 3'd0;
    logic [7:0] elem_data = 8'h00;
    logic       elem_valid = 1'b0;
    logic       elem_ready;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic       error;

    int  checks = 0;
    int  errors = 0;
    bq_t exp_q;
    bq_t elem_q;
    int  tx_cnt = 0;
    int  done_cnt = 0;
    int  err_cnt = 0;
    int  busy_len = 10;
    bit  force_busy = 1'b0;
    bit  withhold = 1'b0;
    int  pr_d0 = 0;
    int  pr_e0 = 0;

    always #5 clk = ~clk;

    matrix_tx_formatter #(.MAX_DIM(MAX_DIM), .CLR_WAIT(CLR_WAIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dim_m      (dim_m),
        .dim_n      (dim_n),
        .elem_data  (elem_data),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected text of a whole matrix, straight from the formatting rules.
    function automatic bq_t fmt_matrix(input int m, input int n, input bq_t e);
        bq_t   q;
        string s;
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                s = $sformatf("%0d", e[r*n + c]);
                for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
                if (c == n - 1) begin
                    q.push_back(8'h0D);
                    q.push_back(8'h0A);
                end else begin
                    q.push_back(8'h20);
                end
            end
        end
        return q;
    endfunction

    // Compare process: every byte, transmit gating, done and error pulses.
    initial begin
        bit prev_busy = 1'b0;
        int since_tx = 100;
        forever begin
            @(negedge clk);
            since_tx++;
            if (rst_n) begin
                if (tx_start) begin
                    tx_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_extra actual=%02h required=no byte", tx_data);
                    end else begin
                        check("tx_data", tx_data, exp_q.pop_front());
                    end
                    check("tx_gate", {prev_busy, since_tx > CLR_WAIT}, 2'b01);
                    since_tx = 0;
                end
                if (done) begin
                    done_cnt++;
                    check("done_after_lf", exp_q.size(), 0);
                end
                if (error) err_cnt++;
            end
            prev_busy = tx_busy;
        end
    end

    // UART model: busy for busy_len cycles after each tx_start, or forced.
    initial begin
        int busy_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (tx_start) busy_cnt = busy_len;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = force_busy || (busy_cnt > 0);
        end
    end

    // Element source with random valid gaps.
    initial begin
        bit xfer;
        forever begin
            @(negedge clk);
            xfer = elem_valid && elem_ready && rst_n;
            @(posedge clk); #1;
            if (!rst_n) begin
                elem_valid = 1'b0;
            end else begin
                if (xfer) begin
                    if (elem_q.size() > 0) void'(elem_q.pop_front());
                    elem_valid = 1'b0;
                end
                if (!elem_valid && !withhold && elem_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    elem_valid = 1'b1;
                    elem_data  = elem_q[0];
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input int m, input int n);
        @(posedge clk); #1;
        dim_m = 3'(m);
        dim_n = 3'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic launch_print(input int m, input int n, input bq_t e);
        bq_t q;
        q = fmt_matrix(m, n, e);
        foreach (q[i]) exp_q.push_back(q[i]);
        foreach (e[i]) elem_q.push_back(e[i]);
        pr_d0 = done_cnt;
        pr_e0 = err_cnt;
        pulse_start(m, n);
    endtask

    task automatic finish_print(input int budget);
        int k = 0;
        while (done_cnt == pr_d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("done_single", done_cnt - pr_d0, 1);
        check("busy_after_done", busy, 0);
        check("stream_drained", exp_q.size(), 0);
        check("no_error", err_cnt - pr_e0, 0);
    endtask

    task automatic wait_tx(input int t0, input int nbytes, input string name);
        int k = 0;
        while (tx_cnt - t0 < nbytes && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check(name, tx_cnt - t0 >= nbytes, 1);
    endtask

    initial begin
        bq_t e;
        bq_t q;
        byte unsigned lit1[15] = '{8'h31, 8'h20, 8'h32, 8'h33, 8'h0D, 8'h0A, 8'h31, 8'h30,
                                   8'h30, 8'h20, 8'h32, 8'h35, 8'h35, 8'h0D, 8'h0A};
        byte unsigned lit2[3]  = '{8'h30, 8'h0D, 8'h0A};
        int t0;
        int e0;
        int k;

        repeat (2) @(negedge clk);
        check("reset_outputs", {elem_ready, tx_start, busy, done, error, tx_data}, 13'h0);
        rst_n = 1'b1;

        // Pin the model against hand-written byte streams.
        e = '{8'd1, 8'd23, 8'd100, 8'd255};
        q = fmt_matrix(2, 2, e);
        check("model_len_2x2", q.size(), 15);
        for (int i = 0; i < 15; i++) check("model_pin_2x2", q[i], lit1[i]);
        e = '{8'd0};
        q = fmt_matrix(1, 1, e);
        check("model_len_1x1", q.size(), 3);
        for (int i = 0; i < 3; i++) check("model_pin_1x1", q[i], lit2[i]);

        busy_len = 10;
        e = '{8'd1, 8'd23, 8'd100, 8'd255};
        launch_print(2, 2, e);
        finish_print(3000);

        e = '{8'd0};
        launch_print(1, 1, e);
        finish_print(1000);

        // Illegal dimensions.
        e0 = err_cnt;
        t0 = tx_cnt;
        pulse_start(0, 3);
        check("error_next_cycle", error, 1);
        check("busy_on_error", busy, 0);
        repeat (3) @(negedge clk);
        pulse_start(6, 2);
        check("error_next_cycle_m6", error, 1);
        repeat (3) @(negedge clk);
        pulse_start(2, 0);
        repeat (3) @(negedge clk);
        check("error_pulses", err_cnt - e0, 3);
        check("no_tx_on_error", tx_cnt - t0, 0);
        check("busy_idle_error", busy, 0);

        // Boundary values and a second start mid-print.
        busy_len = 2;
        e = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255, 8'd101, 8'd50, 8'd7};
        t0 = tx_cnt;
        launch_print(3, 3, e);
        wait_tx(t0, 3, "midprint_progress");
        pulse_start(2, 2);
        check("busy_midprint", busy, 1);
        finish_print(3000);

        // Transmitter stall then element stall.
        busy_len = 1;
        e.delete();
        for (int i = 0; i < 9; i++) e.push_back(8'($urandom_range(0, 255)));
        t0 = tx_cnt;
        launch_print(3, 3, e);
        wait_tx(t0, 2, "stall_progress");
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        t0 = tx_cnt;
        repeat (200) @(negedge clk);
        check("tx_stall_quiet", tx_cnt - t0, 0);
        force_busy = 1'b0;
        withhold = 1'b1;
        k = 0;
        while (!(elem_ready && !elem_valid) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("fetch_reached", elem_ready && !elem_valid, 1);
        t0 = tx_cnt;
        repeat (50) @(negedge clk);
        check("fetch_stall_quiet", tx_cnt - t0, 0);
        check("fetch_stall_ready", elem_ready, 1);
        withhold = 1'b0;
        finish_print(4000);

        // Randomized matrices.
        for (int p = 0; p < 6; p++) begin
            int m = $urandom_range(1, MAX_DIM);
            int n = $urandom_range(1, MAX_DIM);
            busy_len = $urandom_range(0, 3);
            e.delete();
            for (int i = 0; i < m*n; i++) e.push_back(8'($urandom_range(0, 255)));
            launch_print(m, n, e);
            finish_print(6000);
        end

        // Reset after the 4th byte of a 5x5.
        busy_len = 3;
        e.delete();
        e.push_back(8'd7);
        e.push_back(8'd88);
        for (int i = 2; i < 25; i++) e.push_back(8'($urandom_range(0, 255)));
        t0 = tx_cnt;
        launch_print(5, 5, e);
        wait_tx(t0, 4, "reset_progress");
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", {elem_ready, tx_start, busy, done, error, tx_data}, 13'h0);
        elem_q.delete();
        exp_q.delete();
        t0 = tx_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_done_after_reset", done_cnt - pr_d0, 0);
        check("no_tx_after_reset", tx_cnt - t0, 0);
        check("busy_after_reset", busy, 0);
        e = '{8'd42};
        launch_print(1, 1, e);
        finish_print(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
